noc_packet_injector: RTL and testbench
======================================

// Module: noc_packet_injector
// PURPOSE
//  Network-interface source stage sitting directly upstream of a mesh edge/local port.
//  - Accepts packet requests (destination x/y, length) plus a stream of payload words.
//  - Serialises each packet into HEADER, BODY..., TAIL flits.
//  - Drives them into the mesh over the enable/ack flit handshake.
//  - Payload words are buffered in an internal FIFO, so producers may run ahead of the network.
// PARAMETERS
//  FIFO_DEPTH  8   payload FIFO entries; power of two, >= 2
//  MAX_LEN     15  max payload words per packet; LEN_W = $clog2(MAX_LEN+1)
// PORTS
//  clk           in   1        clock
//  rst           in   1        reset, synchronous, active-high
//  req_valid_i   in   1        packet request valid
//  req_ready_o   out  1        request accepted when valid&&ready
//  req_dst_x_i   in   COORD_W  destination x (noc_pkg)
//  req_dst_y_i   in   COORD_W  destination y (noc_pkg)
//  req_len_i     in   LEN_W    payload words in packet, 0..MAX_LEN
//  data_valid_i  in   1        payload word valid
//  data_ready_o  out  1        FIFO not full; word written when valid&&ready
//  data_i        in   PAYLOAD_W payload word
//  flit_o        out  flit_t   flit toward mesh port
//  enable_o      out  1        flit_o valid
//  ack_i         in   1        mesh accepts flit; transfer = enable_o&&ack_i
//  busy_o        out  1        packet in flight (state != IDLE)
//  pkt_count_o   out  16       completed packets, wraps at 2^16
// BEHAVIOUR
//  - Reset values: req_ready_o=1, data_ready_o=1, enable_o=0, flit_o='0, busy_o=0, pkt_count_o=0.
//  - Reset also empties the FIFO and returns the FSM to IDLE.
//  - Reset mid-packet: the packet is abandoned and no TAIL is emitted.
//  - Outputs are registered. Request accepted in cycle N gives enable_o=1 with the HEADER in cycle N+1.
//  - HEADER payload = flit_hdr_t '{dst_addr:'{x,y}, default 0}.
//  - Handshake:
//    - Once enable_o=1, flit_o and enable_o hold stable until the cycle ack_i=1.
//    - enable_o never drops without a transfer.
//    - ack_i is ignored when enable_o=0.
//  - FSM IDLE -> HEAD -> BODY -> TAIL -> IDLE:
//    - IDLE: req_ready_o=1. On accept, latch dst and len into len_q, then go to HEAD.
//    - HEAD: present HEADER. On transfer: len_q<=1 goes to TAIL, else BODY.
//    - BODY: present a BODY flit carrying the FIFO head, but only while the FIFO is non-empty.
//      - FIFO empty: enable_o=0 (bubble) until data arrives.
//      - On transfer: pop and decrement the remaining count; go to TAIL when remaining==1.
//    - TAIL:
//      - len_q>=1: TAIL carries the last payload word and needs a non-empty FIFO.
//      - len_q==0: TAIL carries payload 0 and needs no FIFO data.
//      - On transfer: pop if len_q>=1, pkt_count_o++, go to IDLE.
//  - req_ready_o=1 only in IDLE, so back-to-back packets have a 1-cycle gap (TAIL xfer -> IDLE -> HEAD).
//  - Throughput is 1 flit/cycle while ack_i=1 and the FIFO is non-empty.
//  - req_len_i > MAX_LEN: saturated to MAX_LEN.
//  - FIFO:
//    - Full: data_ready_o=0; a write attempt is dropped (producer must hold).
//    - Push and pop in the same cycle while full: the pop frees the slot, but data_ready_o is registered off the count, so the push still waits one cycle.
//    - Push and pop in the same cycle while empty: not allowed. The pop needs a valid head, so there is no fall-through.
//  - Payload words are not tagged per packet; the producer writes exactly len words per request, in order.
//  - pkt_count_o wraps 16'hFFFF -> 0.
// STRUCTURE
//  - noc_pkg (shared, already holds flit_t): add flit_type_t {HEADER,BODY,TAIL}, flit_hdr_t,
//    COORD_W, PAYLOAD_W, and injector state enum inj_state_t.
//  - Sub-module noc_sync_fifo #(WIDTH,DEPTH):
//    - Synchronous FIFO with push/pop/full/empty/count.
//    - Registered flags, synchronous active-high rst; reused by the sink stage.
//  - Top holds only the FSM, length counter, flit mux and packet counter.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> enable_o=0, req_ready_o=1, data_ready_o=1, pkt_count_o=0.
//  2 Req x=1,y=3,len=2; data A5,5A preloaded; ack_i=1 ->
//    HEADER{1,3} at N+1, BODY A5 at N+2, TAIL 5A at N+3, pkt_count_o=1.
//  3 Same packet with ack_i=0 for 3 cycles at HEADER -> flit_o and enable_o stable all 3 cycles,
//    HEADER transfers exactly once.
//  4 len=3, data words written 1 per 4 cycles -> enable_o=0 bubbles while the FIFO is empty,
//    flits in order, no duplicate or lost word.
//  5 Fill FIFO with 8 words, ack_i=0 -> data_ready_o=0, ninth write ignored;
//    after release all 8 words emerge in order.
//  6 rst=1 during BODY of a len=5 packet -> next cycle enable_o=0, FIFO empty, IDLE;
//    new len=0 request -> HEADER then TAIL payload 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit formats, header layout and injector state encoding.
package noc_pkg;

   localparam int COORD_W   = 4;
   localparam int PAYLOAD_W = 16;

   typedef enum logic [1:0] {
      HEADER = 2'd0,
      BODY   = 2'd1,
      TAIL   = 2'd2
   } flit_type_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } coord_t;

   // Header payload: destination in the top bits, remaining bits reserved as zero.
   typedef struct packed {
      coord_t                          dst_addr;
      logic [PAYLOAD_W-2*COORD_W-1:0]  rsvd;
   } flit_hdr_t;

   typedef struct packed {
      flit_type_t            ftype;
      logic [PAYLOAD_W-1:0]  payload;
   } flit_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HEAD = 2'd1,
      ST_BODY = 2'd2,
      ST_TAIL = 2'd3
   } inj_state_t;

   function automatic flit_t mk_flit(input flit_type_t t, input logic [PAYLOAD_W-1:0] p);
      flit_t f;
      f.ftype   = t;
      f.payload = p;
      return f;
   endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count flags.
// Exposes the head word and the word behind it so a consumer can keep a
// registered output stream going at one word per cycle across a pop.
module noc_sync_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] rdata_nxt,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_p1;
   logic             push_fire;
   logic             pop_fire;
   logic [CW-1:0]    count_nxt;

   assign push_fire = push && !full;
   assign pop_fire  = pop && !empty;
   assign rd_ptr_p1 = rd_ptr + AW'(1);
   assign rdata     = mem[rd_ptr];
   assign rdata_nxt = mem[rd_ptr_p1];

   // Next occupancy, used for both the count and the registered flags.
   always_comb begin
      count_nxt = count;
      case ({push_fire, pop_fire})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage array; contents need no reset since the flags gate every read.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers, count and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop_fire)  rd_ptr <= rd_ptr_p1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/noc_packet_injector.sv
// NoC source stage: turns a packet request plus buffered payload words into
// HEADER/BODY/TAIL flits on the enable/ack mesh port.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a request; no flit presented
// ST_HEAD | HEADER presented, waiting for ack
// ST_BODY | BODY flit presented, or bubbling while the FIFO is empty
// ST_TAIL | TAIL presented (last word, or payload 0 for empty packets)
module noc_packet_injector
   import noc_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   parameter  int MAX_LEN    = 15,
   localparam int LEN_W      = $clog2(MAX_LEN + 1),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [COORD_W-1:0]   req_dst_x_i,
   input  logic [COORD_W-1:0]   req_dst_y_i,
   input  logic [LEN_W-1:0]     req_len_i,
   input  logic                 data_valid_i,
   output logic                 data_ready_o,
   input  logic [PAYLOAD_W-1:0] data_i,
   output flit_t                flit_o,
   output logic                 enable_o,
   input  logic                 ack_i,
   output logic                 busy_o,
   output logic [15:0]          pkt_count_o
);

   inj_state_t           state_q;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     rem_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic [PAYLOAD_W-1:0] fifo_rdata;
   logic [PAYLOAD_W-1:0] fifo_rdata_nxt;
   logic                 push_fire;
   logic                 xfer;
   logic                 pop;
   logic                 nxt_avail;
   logic [PAYLOAD_W-1:0] nxt_word;
   logic [LEN_W-1:0]     len_sat;
   flit_hdr_t            hdr;

   assign data_ready_o = !fifo_full;
   assign push_fire    = data_valid_i && !fifo_full;
   assign xfer         = enable_o && ack_i;
   assign pop          = xfer && ((state_q == ST_BODY) ||
                                  ((state_q == ST_TAIL) && (len_q != '0)));

   noc_sync_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (data_valid_i),
      .wdata     (data_i),
      .pop       (pop),
      .rdata     (fifo_rdata),
      .rdata_nxt (fifo_rdata_nxt),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Word to load into the output register next: after a pop it is the
   // entry behind the head, or the word being pushed right now if that
   // entry does not exist yet.
   always_comb begin
      nxt_avail = !fifo_empty;
      nxt_word  = fifo_rdata;
      if (pop) begin
         if (fifo_count >= CNT_W'(2)) begin
            nxt_avail = 1'b1;
            nxt_word  = fifo_rdata_nxt;
         end else begin
            nxt_avail = push_fire;
            nxt_word  = data_i;
         end
      end
      len_sat = (req_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len_i;
      hdr            = '0;
      hdr.dst_addr.x = req_dst_x_i;
      hdr.dst_addr.y = req_dst_y_i;
   end

   // Injector FSM with registered flit, handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         rem_q       <= '0;
         flit_o      <= '0;
         enable_o    <= 1'b0;
         req_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         pkt_count_o <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  len_q       <= len_sat;
                  rem_q       <= len_sat;
                  flit_o      <= mk_flit(HEADER, hdr);
                  enable_o    <= 1'b1;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  state_q     <= ST_HEAD;
               end
            end
            ST_HEAD: begin
               if (xfer) begin
                  if (len_q == '0) begin
                     flit_o   <= mk_flit(TAIL, '0);
                     enable_o <= 1'b1;
                     state_q  <= ST_TAIL;
                  end else if (len_q == LEN_W'(1)) begin
                     flit_o   <= mk_flit(TAIL, nxt_word);
                     enable_o <= nxt_avail;
                     state_q  <= ST_TAIL;
                  end else begin
                     flit_o   <= mk_flit(BODY, nxt_word);
                     enable_o <= nxt_avail;
                     state_q  <= ST_BODY;
                  end
               end
            end
            ST_BODY: begin
               if (xfer) begin
                  rem_q    <= rem_q - LEN_W'(1);
                  enable_o <= nxt_avail;
                  if (rem_q == LEN_W'(2)) begin
                     flit_o  <= mk_flit(TAIL, nxt_word);
                     state_q <= ST_TAIL;
                  end else begin
                     flit_o  <= mk_flit(BODY, nxt_word);
                  end
               end else if (!enable_o) begin
                  flit_o   <= mk_flit(BODY, nxt_word);
                  enable_o <= nxt_avail;
               end
            end
            ST_TAIL: begin
               if (xfer) begin
                  enable_o    <= 1'b0;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
                  pkt_count_o <= pkt_count_o + 16'd1;
                  state_q     <= ST_IDLE;
               end else if (!enable_o) begin
                  flit_o   <= mk_flit(TAIL, nxt_word);
                  enable_o <= nxt_avail;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: flit sequences are captured at the
// port and compared against hand-built expected sequences.
module tb_noc_packet_injector;
   import noc_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [COORD_W-1:0]   req_dst_x_i;
   logic [COORD_W-1:0]   req_dst_y_i;
   logic [3:0]           req_len_i;
   logic                 data_valid_i;
   logic                 data_ready_o;
   logic [PAYLOAD_W-1:0] data_i;
   flit_t                flit_o;
   logic                 enable_o;
   logic                 ack_i;
   logic                 busy_o;
   logic [15:0]          pkt_count_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] xq[$];
   logic [17:0] eq[$];

   noc_packet_injector #(
      .FIFO_DEPTH (8),
      .MAX_LEN    (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_dst_x_i  (req_dst_x_i),
      .req_dst_y_i  (req_dst_y_i),
      .req_len_i    (req_len_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_o),
      .data_i       (data_i),
      .flit_o       (flit_o),
      .enable_o     (enable_o),
      .ack_i        (ack_i),
      .busy_o       (busy_o),
      .pkt_count_o  (pkt_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every flit that actually crosses the port.
   always @(posedge clk) begin
      if (!rst && enable_o && ack_i) xq.push_back(flit_o);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] p);
      return {t, p};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_xq(input string tag);
      check({tag, "_len"}, 32'(xq.size()), 32'(eq.size()));
      for (int i = 0; i < eq.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), (i < xq.size()) ? 32'(xq[i]) : 32'hDEAD_BEEF,
               32'(eq[i]));
      end
   endtask

   task automatic wait_pkt(input logic [15:0] target);
      int n;
      n = 0;
      while (pkt_count_o != target && n < 200) begin
         tick();
         n++;
      end
      check("wait_pkt", 32'(pkt_count_o), 32'(target));
   endtask

   task automatic push_word(input logic [15:0] w);
      data_valid_i = 1'b1;
      data_i       = w;
      tick();
      data_valid_i = 1'b0;
   endtask

   task automatic send_req(input logic [3:0] x, input logic [3:0] y, input logic [3:0] len);
      req_valid_i = 1'b1;
      req_dst_x_i = x;
      req_dst_y_i = y;
      req_len_i   = len;
      tick();
      req_valid_i = 1'b0;
   endtask

   initial begin
      logic bubble;
      rst = 1'b1;
      req_valid_i = 1'b0;
      req_dst_x_i = '0;
      req_dst_y_i = '0;
      req_len_i = '0;
      data_valid_i = 1'b0;
      data_i = '0;
      ack_i = 1'b0;

      // 1: reset
      tick();
      tick();
      check("rst_enable", 32'(enable_o), 32'd0);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_data_ready", 32'(data_ready_o), 32'd1);
      check("rst_pkt_count", 32'(pkt_count_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_flit", 32'(flit_o), 32'd0);
      rst = 1'b0;
      tick();

      // 2: len=2 with data preloaded, ack held high
      push_word(16'h00A5);
      push_word(16'h005A);
      ack_i = 1'b1;
      xq.delete();
      send_req(4'd1, 4'd3, 4'd2);
      check("t2_hdr_en", 32'(enable_o), 32'd1);
      check("t2_hdr", 32'(flit_o), 32'(mk(2'd0, 16'h1300)));
      check("t2_busy", 32'(busy_o), 32'd1);
      tick();
      check("t2_body", 32'(flit_o), 32'(mk(2'd1, 16'h00A5)));
      tick();
      check("t2_tail", 32'(flit_o), 32'(mk(2'd2, 16'h005A)));
      tick();
      check("t2_idle_en", 32'(enable_o), 32'd0);
      check("t2_pkt_count", 32'(pkt_count_o), 32'd1);
      check("t2_req_ready", 32'(req_ready_o), 32'd1);

      // 3: header stalled by ack low for 3 cycles
      push_word(16'h0011);
      push_word(16'h0022);
      ack_i = 1'b0;
      xq.delete();
      send_req(4'd1, 4'd3, 4'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t3_hold_en%0d", i), 32'(enable_o), 32'd1);
         check($sformatf("t3_hold_flit%0d", i), 32'(flit_o), 32'(mk(2'd0, 16'h1300)));
      end
      ack_i = 1'b1;
      wait_pkt(16'd2);
      eq = '{mk(2'd0, 16'h1300), mk(2'd1, 16'h0011), mk(2'd2, 16'h0022)};
      check_xq("t3_seq");

      // 4: slow producer, one word per 4 cycles
      xq.delete();
      bubble = 1'b0;
      send_req(4'd2, 4'd5, 4'd3);
      for (int i = 0; i < 12; i++) begin
         data_valid_i = (i % 4 == 0);
         data_i = 16'h0031 + 16'(i / 4);
         tick();
         if (busy_o && !enable_o) bubble = 1'b1;
      end
      data_valid_i = 1'b0;
      wait_pkt(16'd3);
      check("t4_bubble", 32'(bubble), 32'd1);
      eq = '{mk(2'd0, 16'h2500), mk(2'd1, 16'h0031), mk(2'd1, 16'h0032), mk(2'd2, 16'h0033)};
      check_xq("t4_seq");

      // 5: fill the FIFO, ninth write dropped, then drain as one len=8 packet
      ack_i = 1'b0;
      for (int i = 0; i < 8; i++) push_word(16'h0050 + 16'(i));
      check("t5_full", 32'(data_ready_o), 32'd0);
      push_word(16'h0058);
      check("t5_still_full", 32'(data_ready_o), 32'd0);
      xq.delete();
      ack_i = 1'b1;
      send_req(4'd3, 4'd7, 4'd8);
      wait_pkt(16'd4);
      eq = '{mk(2'd0, 16'h3700)};
      for (int i = 0; i < 7; i++) eq.push_back(mk(2'd1, 16'h0050 + 16'(i)));
      eq.push_back(mk(2'd2, 16'h0057));
      check_xq("t5_seq");
      check("t5_ready_again", 32'(data_ready_o), 32'd1);

      // len=1: tail must carry the freshly written word, not the dropped one
      push_word(16'h0077);
      xq.delete();
      send_req(4'd1, 4'd1, 4'd1);
      wait_pkt(16'd5);
      eq = '{mk(2'd0, 16'h1100), mk(2'd2, 16'h0077)};
      check_xq("t5b_seq");

      // 6: reset in the middle of a len=5 packet
      for (int i = 0; i < 5; i++) push_word(16'h0061 + 16'(i));
      xq.delete();
      send_req(4'd4, 4'd4, 4'd5);
      tick();
      tick();
      check("t6_in_body", 32'(flit_o), 32'(mk(2'd1, 16'h0062)));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_en", 32'(enable_o), 32'd0);
      check("t6_rst_busy", 32'(busy_o), 32'd0);
      check("t6_rst_req_ready", 32'(req_ready_o), 32'd1);
      check("t6_rst_data_ready", 32'(data_ready_o), 32'd1);
      check("t6_rst_pkt", 32'(pkt_count_o), 32'd0);
      eq = '{mk(2'd0, 16'h4400), mk(2'd1, 16'h0061)};
      check_xq("t6_abandoned");

      xq.delete();
      send_req(4'd2, 4'd2, 4'd0);
      wait_pkt(16'd1);
      eq = '{mk(2'd0, 16'h2200), mk(2'd2, 16'h0000)};
      check_xq("t6_len0");

      // FIFO must be empty after the reset: a len=1 tail has to wait for data
      xq.delete();
      send_req(4'd5, 4'd6, 4'd1);
      for (int i = 0; i < 4; i++) tick();
      check("t6_empty_wait", 32'(enable_o), 32'd0);
      check("t6_empty_busy", 32'(busy_o), 32'd1);
      push_word(16'h0099);
      wait_pkt(16'd2);
      eq = '{mk(2'd0, 16'h5600), mk(2'd2, 16'h0099)};
      check_xq("t6_len1");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
